// File: rtl/tree_feature_sequencer_if.sv
// ---------------------------------------------------------------------------
// tree_feature_sequencer_if
// Bundles every data/handshake signal of the tree feature sequencer so the
// design and its surroundings connect through one port.
//
// Signals
//   in_valid/in_first/in_data/in_ready : upstream byte stream (first-byte flag)
//   X13, X27, X235, X264, X278         : registered features to the classifier
//   class_in                           : class returned by the classifier
//   out_valid/out_ready/out_class      : downstream result handshake
//   frame_errs                         : saturating framing-error count
//   sample_cnt                         : wrapping count of delivered results
//
// Modports
//   master : the environment (drives bytes, class_in, out_ready)
//   slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface tree_feature_sequencer_if;
  logic        in_valid;
  logic        in_first;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [7:0]  X13;
  logic [7:0]  X27;
  logic [7:0]  X235;
  logic [7:0]  X264;
  logic [7:0]  X278;
  logic [4:0]  class_in;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_class;
  logic [7:0]  frame_errs;
  logic [15:0] sample_cnt;

  // The environment side: produces bytes and the classifier answer,
  // consumes results and status.
  modport master (
    output in_valid, in_first, in_data, class_in, out_ready,
    input  in_ready, X13, X27, X235, X264, X278,
           out_valid, out_class, frame_errs, sample_cnt
  );

  // The sequencer side.
  modport slave (
    input  in_valid, in_first, in_data, class_in, out_ready,
    output in_ready, X13, X27, X235, X264, X278,
           out_valid, out_class, frame_errs, sample_cnt
  );
endinterface

// File: rtl/tree_feature_sequencer.sv
// ---------------------------------------------------------------------------
// tree_feature_sequencer
// Collects a five-byte feature frame (X13, X27, X235, X264, X278) from a
// valid/ready byte stream, holds the features steady for an external
// combinational tree classifier, waits SETTLE_CYCLES for its answer to
// settle, captures the class and offers it downstream with valid/ready.
//
// Ports
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : tree_feature_sequencer_if.slave (byte input, features, class_in,
//         result handshake, frame_errs and sample_cnt status)
//
// Parameter
//   SETTLE_CYCLES : 1..15, classifier settle time after the last byte
// ---------------------------------------------------------------------------
module tree_feature_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  tree_feature_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    OUT    = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  state_t      state_q,     state_d;
  logic [2:0]  idx_q,       idx_d;
  logic [3:0]  cnt_q,       cnt_d;
  logic [7:0]  featRegs_q [5];
  logic [7:0]  featRegs_d [5];
  logic        outValid_q,  outValid_d;
  logic [4:0]  outClass_q,  outClass_d;
  logic [7:0]  frameErrs_q, frameErrs_d;
  logic [15:0] sampleCnt_q, sampleCnt_d;
  logic        errEvent;

  // State register: every piece of state lives here and is cleared together
  // by the synchronous reset, which also aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      idx_q       <= 3'd0;
      cnt_q       <= 4'd0;
      featRegs_q  <= '{default: 8'h00};
      outValid_q  <= 1'b0;
      outClass_q  <= 5'd0;
      frameErrs_q <= 8'd0;
      sampleCnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      featRegs_q  <= featRegs_d;
      outValid_q  <= outValid_d;
      outClass_q  <= outClass_d;
      frameErrs_q <= frameErrs_d;
      sampleCnt_q <= sampleCnt_d;
    end
  end

  // Next-state logic. Bytes are only taken in LOAD, so the feature registers
  // stay frozen while the classifier settles and while the result waits.
  // A first-flagged byte always restarts the frame at X13; a byte without
  // the flag and no frame open is discarded. Either irregularity bumps the
  // error counter once, saturating at 255. The settle counter is loaded with
  // SETTLE_CYCLES and the class is captured on the cycle it reads 1, which
  // makes the result appear SETTLE_CYCLES+1 cycles after the last byte.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    featRegs_d  = featRegs_q;
    outValid_d  = outValid_q;
    outClass_d  = outClass_q;
    frameErrs_d = frameErrs_q;
    sampleCnt_d = sampleCnt_q;
    errEvent    = 1'b0;

    case (state_q)
      LOAD: begin
        if (bus.in_valid) begin
          if (bus.in_first) begin
            featRegs_d[0] = bus.in_data;
            idx_d         = 3'd1;
            errEvent      = (idx_q != 3'd0);
          end else if (idx_q == 3'd0) begin
            errEvent = 1'b1;
          end else begin
            featRegs_d[idx_q] = bus.in_data;
            if (idx_q == 3'd4) begin
              idx_d   = 3'd0;
              cnt_d   = SETTLE_LOAD;
              state_d = SETTLE;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end
      end
      SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          outClass_d = bus.class_in;
          outValid_d = 1'b1;
          state_d    = OUT;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          sampleCnt_d = sampleCnt_q + 16'd1;
          outValid_d  = 1'b0;
          state_d     = LOAD;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase

    if (errEvent && (frameErrs_q != 8'hFF)) begin
      frameErrs_d = frameErrs_q + 8'd1;
    end
  end

  // Output mapping: the byte stream is back-pressured whenever a frame is
  // being evaluated or its result has not yet been taken.
  assign bus.in_ready   = (state_q == LOAD);
  assign bus.X13        = featRegs_q[0];
  assign bus.X27        = featRegs_q[1];
  assign bus.X235       = featRegs_q[2];
  assign bus.X264       = featRegs_q[3];
  assign bus.X278       = featRegs_q[4];
  assign bus.out_valid  = outValid_q;
  assign bus.out_class  = outClass_q;
  assign bus.frame_errs = frameErrs_q;
  assign bus.sample_cnt = sampleCnt_q;

endmodule

// File: tb/tb_tree_feature_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tree_feature_sequencer
// Self-checking bench for tree_feature_sequencer. A frame-level model turns
// each accepted byte into expected features/class/error counts; completed
// frames are queued and a monitor compares them when the DUT presents a
// result. The classifier is a small behavioural function of the features.
// ---------------------------------------------------------------------------
module tb_tree_feature_sequencer;

  localparam int SETTLE = 2;

  typedef struct packed {
    logic [4:0]  cls;
    logic [39:0] feats;
    logic [31:0] acceptCyc;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tree_feature_sequencer_if bus ();

  tree_feature_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    readyMode = 2;
  int    forceClass = -1;
  int    mIdx = 0;
  logic [7:0] mFeat [5];
  int    errExp = 0;
  int    sampleExp = 0;
  item_t expQ [$];
  logic  prevValid = 1'b0;

  // Stand-in for the combinational tree classifier.
  function automatic logic [4:0] classify(input logic [7:0] a, b, c, d, e);
    logic [7:0] s;
    s = a + {b[6:0], 1'b0} + (c ^ d) + {e[3:0], e[7:4]};
    return s[4:0] ^ {2'b00, d[7:5]};
  endfunction

  assign bus.class_in = (forceClass >= 0) ? 5'(forceClass)
                      : classify(bus.X13, bus.X27, bus.X235, bus.X264, bus.X278);

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream acceptance, changed just after the rising edge.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0:       bus.out_ready = ($urandom_range(0, 3) != 0);
        1:       bus.out_ready = 1'b0;
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic void bumpErr();
    if (errExp < 255) errExp++;
  endfunction

  // Frame rules applied to one accepted byte.
  function automatic void modelAccept(input logic first, input logic [7:0] data, input int accCyc);
    item_t it;
    if (first) begin
      if (mIdx != 0) bumpErr();
      mFeat[0] = data;
      mIdx = 1;
    end else if (mIdx == 0) begin
      bumpErr();
    end else begin
      mFeat[mIdx] = data;
      if (mIdx == 4) begin
        it.feats = {mFeat[0], mFeat[1], mFeat[2], mFeat[3], mFeat[4]};
        it.cls = (forceClass >= 0) ? 5'(forceClass)
               : classify(mFeat[0], mFeat[1], mFeat[2], mFeat[3], mFeat[4]);
        it.acceptCyc = 32'(accCyc);
        expQ.push_back(it);
        mIdx = 0;
      end else begin
        mIdx++;
      end
    end
  endfunction

  // Offer one byte and hold it until the DUT takes it.
  task automatic applyStimulus(input logic first, input logic [7:0] data);
    int waited = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_first = first;
    bus.in_data  = data;
    while (!bus.in_ready) begin
      if (waited > 200) begin
        checks++;
        errors++;
        $display("[TB] FAIL in_ready_timeout actual=0 required=1 after %0d cycles", waited);
        bus.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      waited++;
    end
    modelAcceptAt(first, data, cyc);
  endtask

  task automatic modelAcceptAt(input logic first, input logic [7:0] data, input int accCyc);
    @(posedge clk);
    modelAccept(first, data, accCyc);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic sendFrame(input logic [7:0] b0, b1, b2, b3, b4);
    applyStimulus(1'b1, b0);
    applyStimulus(1'b0, b1);
    applyStimulus(1'b0, b2);
    applyStimulus(1'b0, b3);
    applyStimulus(1'b0, b4);
  endtask

  task automatic waitIdle();
    int n = 0;
    @(negedge clk);
    while (expQ.size() != 0 || bus.out_valid) begin
      if (n > 300) begin
        checks++;
        errors++;
        $display("[TB] FAIL idle_timeout actual pending=%0d required pending=0", expQ.size());
        return;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    expQ.delete();
    mIdx = 0;
    for (int i = 0; i < 5; i++) mFeat[i] = 8'h00;
    errExp = 0;
    sampleExp = 0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_out_valid"},  32'(bus.out_valid), 0);
    checkOutput({tag, "_out_class"},  32'(bus.out_class), 0);
    checkOutput({tag, "_features"},   32'({bus.X13, bus.X27, bus.X235, bus.X264}), 0);
    checkOutput({tag, "_X278"},       32'(bus.X278), 0);
    checkOutput({tag, "_frame_errs"}, 32'(bus.frame_errs), 0);
    checkOutput({tag, "_sample_cnt"}, 32'(bus.sample_cnt), 0);
    checkOutput({tag, "_in_ready"},   32'(bus.in_ready), 1);
  endtask

  // Result monitor: checks each new result against the head of the queue and
  // retires it when the downstream side accepts it.
  always @(negedge clk) begin
    if (rst) begin
      prevValid = 1'b0;
    end else begin
      if (bus.out_valid && !prevValid) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_result actual out_valid=1 required no result pending");
        end else begin
          checkOutput("out_class", 32'(bus.out_class), 32'(expQ[0].cls));
          checkOutput("features_held",
                      {bus.X13, bus.X27, bus.X235, bus.X264}, expQ[0].feats[39:8]);
          checkOutput("X278_held", 32'(bus.X278), 32'(expQ[0].feats[7:0]));
          checkOutput("latency", 32'(cyc) - expQ[0].acceptCyc, 32'(SETTLE + 1));
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        checkOutput("sample_cnt_before", 32'(bus.sample_cnt), 32'(sampleExp));
        sampleExp = (sampleExp + 1) & 16'hFFFF;
        if (expQ.size() != 0) void'(expQ.pop_front());
      end
      prevValid = bus.out_valid;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seen;
    logic [4:0] heldCls;
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_data  = 8'h00;
    for (int i = 0; i < 5; i++) mFeat[i] = 8'h00;

    $display("[TB] reset state");
    doReset();
    checkResetState("reset");

    $display("[TB] reference frame with class 7");
    readyMode = 2;
    forceClass = 7;
    sendFrame(8'h10, 8'h20, 8'h30, 8'h40, 8'h20);
    waitIdle();
    forceClass = -1;
    checkOutput("ref_sample_cnt", 32'(bus.sample_cnt), 1);
    checkOutput("ref_X13_held", 32'(bus.X13), 32'h10);

    $display("[TB] stray byte while idle");
    applyStimulus(1'b0, 8'h55);
    @(negedge clk);
    checkOutput("stray_frame_errs", 32'(bus.frame_errs), 1);
    checkOutput("stray_X13", 32'(bus.X13), 32'h10);

    $display("[TB] restart on third byte");
    applyStimulus(1'b1, 8'hA1);
    applyStimulus(1'b0, 8'hA2);
    applyStimulus(1'b1, 8'hB0);
    @(negedge clk);
    checkOutput("restart_frame_errs", 32'(bus.frame_errs), 2);
    checkOutput("restart_X13", 32'(bus.X13), 32'hB0);
    applyStimulus(1'b0, 8'hB1);
    applyStimulus(1'b0, 8'hB2);
    applyStimulus(1'b0, 8'hB3);
    applyStimulus(1'b0, 8'hB4);
    waitIdle();
    checkOutput("restart_sample_cnt", 32'(bus.sample_cnt), 2);

    $display("[TB] downstream stall");
    readyMode = 1;
    @(negedge clk);
    sendFrame(8'h01, 8'h82, 8'h43, 8'hC4, 8'h25);
    seen = 0;
    while (!bus.out_valid && seen < 20) begin
      @(negedge clk);
      seen++;
    end
    heldCls = classify(8'h01, 8'h82, 8'h43, 8'hC4, 8'h25);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_first = 1'b1;
      bus.in_data  = 8'hAA;
      checkOutput("stall_in_ready", 32'(bus.in_ready), 0);
      checkOutput("stall_out_valid", 32'(bus.out_valid), 1);
      checkOutput("stall_out_class", 32'(bus.out_class), 32'(heldCls));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    readyMode = 2;
    waitIdle();
    checkOutput("stall_X13", 32'(bus.X13), 32'h01);
    checkOutput("stall_frame_errs", 32'(bus.frame_errs), 32'(errExp));

    $display("[TB] reset during settle");
    sendFrame(8'h11, 8'h22, 8'h33, 8'h44, 8'h55);
    doReset();
    checkResetState("abort");
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    checkOutput("abort_no_result", 32'(seen), 0);
    sendFrame(8'h66, 8'h77, 8'h88, 8'h99, 8'hAA);
    waitIdle();
    checkOutput("abort_next_sample_cnt", 32'(bus.sample_cnt), 1);

    $display("[TB] error counter saturation");
    for (int i = 0; i < 300; i++) applyStimulus(1'b0, 8'($urandom_range(0, 255)));
    @(negedge clk);
    checkOutput("sat_frame_errs", 32'(bus.frame_errs), 255);
    checkOutput("sat_model_errs", 32'(bus.frame_errs), 32'(errExp));

    $display("[TB] randomized frames");
    readyMode = 0;
    for (int f = 0; f < 150; f++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      for (int b = 0; b < 5; b++) begin
        logic first;
        first = (b == 0);
        if ($urandom_range(0, 15) == 0) first = ~first;
        applyStimulus(first, 8'($urandom_range(0, 255)));
      end
    end
    // Close any frame left open by an injected error so the queue drains.
    if (mIdx != 0) begin
      for (int b = mIdx; b < 5; b++) applyStimulus(1'b0, 8'($urandom_range(0, 255)));
    end
    readyMode = 2;
    waitIdle();
    checkOutput("final_frame_errs", 32'(bus.frame_errs), 32'(errExp));
    checkOutput("final_sample_cnt", 32'(bus.sample_cnt), 32'(sampleExp));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tree_feature_sequencer.md
TREE_FEATURE_SEQUENCER -- requirements
Module: tree_feature_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, range 1..15: cycles that class_in must settle after the feature vector is complete before capture.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: upstream byte valid.
REQ-005 SHALL have port in_first, input, 1 bit: marks the first byte of a sample frame.
REQ-006 SHALL have port in_data, input, 8 bits: feature byte; frame order is X13, X27, X235, X264, X278.
REQ-007 SHALL have port in_ready, output, 1 bit: byte accepted when in_valid and in_ready are both 1.
REQ-008 SHALL have ports X13, X27, X235, X264, X278, output, 8 bits each: registered features driven to the combinational classifier.
REQ-009 SHALL have port class_in, input, 5 bits: class returned by the classifier.
REQ-010 SHALL have port out_valid, output, 1 bit: result valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accept.
REQ-012 SHALL have port out_class, output, 5 bits: captured class.
REQ-013 SHALL have port frame_errs, output, 8 bits: saturating framing-error count.
REQ-014 SHALL have port sample_cnt, output, 16 bits: wrapping count of delivered results.

Function
REQ-015 SHALL implement FSM states LOAD, SETTLE, OUT; in_ready = 1 only in LOAD.
REQ-016 In LOAD, SHALL keep byte index idx (0..4); an accepted byte SHALL be written to the feature register selected by idx.
REQ-017 An accepted byte with in_first=1 SHALL always be written to X13 and set idx=1; if idx was not 0, frame_errs SHALL increment.
REQ-018 An accepted byte with in_first=0 while idx=0 SHALL be dropped (no register written), and frame_errs SHALL increment.
REQ-019 frame_errs SHALL saturate at 255; it SHALL increment at most once per cycle.
REQ-020 Accepting the byte with idx=4 SHALL write X278, reset idx to 0, load the settle counter with SETTLE_CYCLES, and move to SETTLE on the next cycle.
REQ-021 In SETTLE, the counter SHALL decrement each cycle; the cycle it reads 1, out_class SHALL capture class_in, out_valid SHALL rise the next cycle, and the state SHALL become OUT.
REQ-022 Latency from the accepted X278 byte to out_valid=1 SHALL be SETTLE_CYCLES+1 cycles.
REQ-023 Feature registers SHALL hold their value through SETTLE and OUT; they are not modified outside LOAD.
REQ-024 In OUT, out_valid and out_class SHALL hold until out_ready=1; on that cycle sample_cnt SHALL increment (wrapping 65535 -> 0), out_valid SHALL clear next cycle, and the state SHALL return to LOAD.
REQ-025 in_ready SHALL be 0 in SETTLE and OUT; upstream back-pressure is the only flow control, and no bytes are lost.
REQ-026 out_ready asserted while out_valid=0 SHALL have no effect.

Reset
REQ-027 While rst=1, outputs SHALL take these values on the next edge: state LOAD, idx 0, X13..X278 = 0, out_valid 0, out_class 0, frame_errs 0, sample_cnt 0, in_ready 1 from the first cycle after rst falls.
REQ-028 rst asserted during SETTLE or OUT SHALL abort the frame; no result is delivered and sample_cnt is unchanged from 0.

Verification
REQ-029 Frame 0x10(first),0x20,0x30,0x40,0x20, class_in=7, out_ready=1, SETTLE_CYCLES=2 -> out_valid 3 cycles after the last byte, out_class=7, sample_cnt=1, features held.
REQ-030 Byte 0x55 with in_first=0 in the idle state -> byte dropped, frame_errs=1, X13 unchanged.
REQ-031 in_first on the 3rd byte of a frame -> frame_errs=1, byte lands in X13, idx=1, the frame completes after 4 more bytes.
REQ-032 out_ready held 0 for 10 cycles while in_valid=1 -> out_valid and out_class stable, in_ready=0, no bytes accepted.
REQ-033 300 misframed bytes -> frame_errs=255 (saturated); 65536 delivered frames -> sample_cnt=0.
REQ-034 rst pulsed during SETTLE -> all outputs at reset values, no out_valid, next frame processed normally.
